// File: rtl/router_pkg.sv
// Shared definitions for the 1xN router control path: state encodings used by
// the FSM, the register block and monitors, plus a small width helper.
package router_pkg;

    // State register width; every block that decodes router states uses this.
    localparam int STATE_W = 4;

    typedef logic [STATE_W-1:0] router_state_t;

    // Router FSM state encodings.
    localparam logic [3:0] DECODE_ADDRESS     = 4'd0;
    localparam logic [3:0] LOAD_FIRST_DATA    = 4'd1;
    localparam logic [3:0] LOAD_DATA          = 4'd2;
    localparam logic [3:0] LOAD_PARITY        = 4'd3;
    localparam logic [3:0] FIFO_FULL_STATE    = 4'd4;
    localparam logic [3:0] LOAD_AFTER_FULL    = 4'd5;
    localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd6;
    localparam logic [3:0] CHECK_PARITY_ERROR = 4'd7;
    localparam logic [3:0] DROP_PACKET        = 4'd8;

    // Ceiling log2, with a floor of 1 so it can size a one-entry field.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : router_pkg

// File: rtl/router_wait_timer.sv
// Counts the cycles the router spends in WAIT_TILL_EMPTY.
// Clear has priority over enable. The count saturates at all-ones and never wraps.
// o_terminal is high on the last permitted wait cycle. It stays low when TIMEOUT is 0.
module router_wait_timer #(
    parameter int TMR_W   = 16,
    parameter int TIMEOUT = 0
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    // The last wait cycle is when the count reaches TIMEOUT-1.
    // With TIMEOUT 0 this value is unused.
    localparam logic [TMR_W-1:0] TERMINAL_COUNT =
        (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] r_count;
    logic             w_saturated;

    assign w_saturated = (r_count == {TMR_W{1'b1}});

    // Wait counter: clear wins, then count up unless already at the ceiling.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_saturated) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (TIMEOUT != 0) && (r_count == TERMINAL_COUNT);

endmodule : router_wait_timer

// File: rtl/router_fsm_nport.sv
// Control FSM for a 1xN router with NUM_PORTS output FIFOs.
// The header address is latched when the packet starts. Headers with an
// out-of-range address are dropped. WAIT_TILL_EMPTY can time out.
// A soft reset of the selected FIFO aborts the packet in flight.
// All strobes are Moore decodes of the state register.
module router_fsm_nport
    import router_pkg::*;
#(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 0,
    parameter int TMR_W        = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_packet_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic                 drop_state,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic                 wait_timeout
);

    router_state_t          r_state;
    router_state_t          w_next;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_waitTimeout;

    logic [NUM_PORTS-1:0]   w_addrHot;
    logic [NUM_PORTS-1:0]   w_dinHot;
    logic                   w_addrOk;
    logic                   w_emptyDin;
    logic                   w_emptySel;
    logic                   w_softSel;
    logic                   w_abort;
    logic                   w_terminal;
    logic                   w_timeoutNow;
    logic                   w_stayWait;

    // One-hot decodes of the latched and the live address. An address with no
    // matching port yields all zeros, so no vector is indexed out of range.
    always_comb begin
        w_addrHot = '0;
        w_dinHot  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_addrHot[i] = (r_addr  == ADDR_W'(i));
            w_dinHot[i]  = (data_in == ADDR_W'(i));
        end
    end

    assign w_addrOk   = |w_dinHot;
    assign w_emptyDin = |(fifo_empty & w_dinHot);
    assign w_emptySel = |(fifo_empty & w_addrHot);
    assign w_softSel  = |(soft_reset & w_addrHot);

    // A soft reset only aborts a packet that is actually using the selected port.
    assign w_abort = w_softSel &&
                     (r_state != DECODE_ADDRESS) &&
                     (r_state != DROP_PACKET);

    // Next-state logic. A soft-reset abort overrides every other transition,
    // including a WAIT timeout that lands on the same cycle.
    always_comb begin
        w_next       = DECODE_ADDRESS;
        w_timeoutNow = 1'b0;
        case (r_state)
            DECODE_ADDRESS: begin
                if (pkt_valid && !w_addrOk)
                    w_next = DROP_PACKET;
                else if (pkt_valid && w_emptyDin)
                    w_next = LOAD_FIRST_DATA;
                else if (pkt_valid)
                    w_next = WAIT_TILL_EMPTY;
                else
                    w_next = DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (w_terminal) begin
                    w_next       = DECODE_ADDRESS;
                    w_timeoutNow = 1'b1;
                end else if (w_emptySel) begin
                    w_next = LOAD_FIRST_DATA;
                end else begin
                    w_next = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: begin
                w_next = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (fifo_full)
                    w_next = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    w_next = LOAD_PARITY;
                else
                    w_next = LOAD_DATA;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    w_next = LOAD_AFTER_FULL;
                else
                    w_next = FIFO_FULL_STATE;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    w_next = DECODE_ADDRESS;
                else if (low_packet_valid)
                    w_next = LOAD_PARITY;
                else
                    w_next = LOAD_DATA;
            end
            LOAD_PARITY: begin
                w_next = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                if (fifo_full)
                    w_next = FIFO_FULL_STATE;
                else
                    w_next = DECODE_ADDRESS;
            end
            DROP_PACKET: begin
                if (!pkt_valid)
                    w_next = DECODE_ADDRESS;
                else
                    w_next = DROP_PACKET;
            end
            default: begin
                w_next = DECODE_ADDRESS;
            end
        endcase

        if (w_abort) begin
            w_next       = DECODE_ADDRESS;
            w_timeoutNow = 1'b0;
        end
    end

    // The timer counts only while the FSM remains in WAIT_TILL_EMPTY.
    // Any exit clears it, so the next wait starts from zero.
    assign w_stayWait = (r_state == WAIT_TILL_EMPTY) && (w_next == WAIT_TILL_EMPTY);

    router_wait_timer #(
        .TMR_W   (TMR_W),
        .TIMEOUT (WAIT_TIMEOUT)
    ) u_waitTimer (
        .clock      (clock),
        .resetn     (resetn),
        .i_clear    (!w_stayWait),
        .i_enable   (w_stayWait),
        .o_terminal (w_terminal)
    );

    // State register. Reset always returns to address decode.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the header address once the packet starts.
    // Later decisions never look at live data_in.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_addr <= '0;
        end else if ((r_state == DECODE_ADDRESS) && pkt_valid) begin
            r_addr <= data_in;
        end
    end

    // Registered single-cycle pulse that reports a WAIT timeout abort.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_waitTimeout <= 1'b0;
        end else begin
            r_waitTimeout <= w_timeoutNow;
        end
    end

    assign detect_add    = (r_state == DECODE_ADDRESS);
    assign lfd_state     = (r_state == LOAD_FIRST_DATA);
    assign ld_state      = (r_state == LOAD_DATA);
    assign laf_state     = (r_state == LOAD_AFTER_FULL);
    assign full_state    = (r_state == FIFO_FULL_STATE);
    assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    assign drop_state    = (r_state == DROP_PACKET);
    assign write_enb_reg = (r_state == LOAD_DATA) ||
                           (r_state == LOAD_PARITY) ||
                           (r_state == LOAD_AFTER_FULL);
    assign busy          = !((r_state == DECODE_ADDRESS) ||
                             (r_state == LOAD_DATA) ||
                             (r_state == DROP_PACKET));
    assign dest_sel      = ((r_state == DECODE_ADDRESS) || (r_state == DROP_PACKET))
                           ? '0 : w_addrHot;
    assign wait_timeout  = r_waitTimeout;

endmodule : router_fsm_nport

// File: tb/tb_router_fsm_nport.sv
// Self-checking bench for router_fsm_nport with three ports and a 4-cycle wait timeout.
// A behavioural packet-level model predicts every output after each clock.
// Directed scenarios run first, then a long randomized run.
module tb_router_fsm_nport;

    localparam int NP      = 3;
    localparam int AW      = 2;
    localparam int TIMEOUT = 4;
    localparam int TW      = 8;

    logic          clock;
    logic          resetn;
    logic          pktValid;
    logic [AW-1:0] dataIn;
    logic          fifoFull;
    logic [NP-1:0] fifoEmpty;
    logic [NP-1:0] softReset;
    logic          parityDone;
    logic          lowPacketValid;

    logic          detectAdd, lfdState, ldState, lafState, fullState;
    logic          rstIntReg, writeEnbReg, busy, dropState, waitTimeout;
    logic [NP-1:0] destSel;

    int checks = 0;
    int errors = 0;

    // Model state: which phase of packet handling the router is in.
    typedef enum {M_IDLE, M_FIRST, M_DATA, M_FULL, M_AFTERFULL,
                  M_PARITY, M_CHECK, M_WAIT, M_DROP} phase_t;
    phase_t mPhase;
    int     mAddr;
    int     mWaited;
    bit     mPulse;

    router_fsm_nport #(
        .NUM_PORTS    (NP),
        .ADDR_W       (AW),
        .WAIT_TIMEOUT (TIMEOUT),
        .TMR_W        (TW)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pktValid),
        .data_in          (dataIn),
        .fifo_full        (fifoFull),
        .fifo_empty       (fifoEmpty),
        .soft_reset       (softReset),
        .parity_done      (parityDone),
        .low_packet_valid (lowPacketValid),
        .detect_add       (detectAdd),
        .lfd_state        (lfdState),
        .ld_state         (ldState),
        .laf_state        (lafState),
        .full_state       (fullState),
        .rst_int_reg      (rstIntReg),
        .write_enb_reg    (writeEnbReg),
        .busy             (busy),
        .drop_state       (dropState),
        .dest_sel         (destSel),
        .wait_timeout     (waitTimeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advances the model by one clock, using the inputs that were just applied.
    task automatic modelStep();
        phase_t nxt;
        bit     pulse;
        if (!resetn) begin
            mPhase  = M_IDLE;
            mAddr   = 0;
            mWaited = 0;
            mPulse  = 0;
        end else begin
            nxt   = mPhase;
            pulse = 0;
            if (mPhase == M_IDLE) begin
                if (pktValid) begin
                    mAddr = int'(dataIn);
                    if (mAddr >= NP)          nxt = M_DROP;
                    else if (fifoEmpty[mAddr]) nxt = M_FIRST;
                    else                       nxt = M_WAIT;
                end
            end else if (mPhase != M_DROP && softReset[mAddr]) begin
                nxt = M_IDLE;
            end else begin
                case (mPhase)
                    M_WAIT: begin
                        if (TIMEOUT != 0 && mWaited + 1 == TIMEOUT) begin
                            nxt   = M_IDLE;
                            pulse = 1;
                        end else if (fifoEmpty[mAddr]) begin
                            nxt = M_FIRST;
                        end
                    end
                    M_FIRST:     nxt = M_DATA;
                    M_DATA:      nxt = fifoFull ? M_FULL : (!pktValid ? M_PARITY : M_DATA);
                    M_FULL:      nxt = fifoFull ? M_FULL : M_AFTERFULL;
                    M_AFTERFULL: nxt = parityDone ? M_IDLE : (lowPacketValid ? M_PARITY : M_DATA);
                    M_PARITY:    nxt = M_CHECK;
                    M_CHECK:     nxt = fifoFull ? M_FULL : M_IDLE;
                    M_DROP:      nxt = pktValid ? M_DROP : M_IDLE;
                    default:     nxt = M_IDLE;
                endcase
            end
            mWaited = (mPhase == M_WAIT && nxt == M_WAIT) ? mWaited + 1 : 0;
            mPhase  = nxt;
            mPulse  = pulse;
        end
    endtask

    // Compares every DUT output with the model.
    task automatic compareAll();
        logic [8:0]    expStrobes;
        logic [NP-1:0] expDest;
        expStrobes = {mPhase == M_IDLE, mPhase == M_FIRST, mPhase == M_DATA,
                      mPhase == M_AFTERFULL, mPhase == M_FULL, mPhase == M_CHECK,
                      (mPhase == M_DATA) || (mPhase == M_PARITY) || (mPhase == M_AFTERFULL),
                      !((mPhase == M_IDLE) || (mPhase == M_DATA) || (mPhase == M_DROP)),
                      mPhase == M_DROP};
        expDest = (mPhase == M_IDLE || mPhase == M_DROP) ? '0 : NP'(1 << mAddr);
        checkOutput("strobes", 32'({detectAdd, lfdState, ldState, lafState, fullState,
                                    rstIntReg, writeEnbReg, busy, dropState}), 32'(expStrobes));
        checkOutput("dest_sel", 32'(destSel), 32'(expDest));
        checkOutput("wait_timeout", 32'(waitTimeout), 32'(mPulse));
    endtask

    // Drives one cycle of inputs on the falling edge and steps the model at the rising edge.
    // The DUT is then compared one time unit later.
    task automatic applyStimulus(input bit rstN, input bit pv, input logic [AW-1:0] din,
                                 input bit full, input logic [NP-1:0] empty,
                                 input logic [NP-1:0] sr, input bit pd, input bit lpv);
        @(negedge clock);
        resetn         = rstN;
        pktValid       = pv;
        dataIn         = din;
        fifoFull       = full;
        fifoEmpty      = empty;
        softReset      = sr;
        parityDone     = pd;
        lowPacketValid = lpv;
        @(posedge clock);
        modelStep();
        #1;
        compareAll();
    endtask

    initial begin
        resetn = 1'b0; pktValid = 1'b0; dataIn = '0; fifoFull = 1'b0;
        fifoEmpty = '1; softReset = '0; parityDone = 1'b0; lowPacketValid = 1'b0;
        mPhase = M_IDLE; mAddr = 0; mWaited = 0; mPulse = 0;

        // Reset state.
        applyStimulus(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        applyStimulus(0, 1, 2'd2, 1, 3'b000, 3'b111, 1, 1);
        checkOutput("reset_detect_add", 32'(detectAdd), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);

        // Header to an empty port 1 goes straight to the first-data load.
        applyStimulus(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0);
        checkOutput("lfd_dest_sel", 32'(destSel), 32'b010);
        checkOutput("lfd_busy", 32'(busy), 32'd1);
        applyStimulus(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0);

        // Busy port 1. A changing data_in during the wait must not move the target.
        applyStimulus(1, 1, 2'd1, 0, 3'b101, 3'b000, 0, 0);
        applyStimulus(1, 1, 2'd0, 0, 3'b101, 3'b000, 0, 0);
        applyStimulus(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        checkOutput("wait_then_lfd_port1", 32'(destSel), 32'b010);
        applyStimulus(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0);

        // Out-of-range address 3: the packet drains through DROP with no writes.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0);
            checkOutput("drop_write_enb", 32'(writeEnbReg), 32'd0);
        end
        applyStimulus(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        checkOutput("drop_back_to_decode", 32'(detectAdd), 32'd1);

        // Port 2 never empties: four cycles in WAIT, then a one-cycle timeout pulse.
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0);
        checkOutput("timeout_pulse", 32'(waitTimeout), 32'd1);
        applyStimulus(1, 0, 2'd0, 0, 3'b011, 3'b000, 0, 0);
        checkOutput("timeout_pulse_end", 32'(waitTimeout), 32'd0);

        // Full FIFO, then a soft reset on another port (ignored) and on the selected one (abort).
        applyStimulus(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 1, 2'd1, 1, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 1, 2'd1, 1, 3'b111, 3'b101, 0, 0);
        checkOutput("other_soft_reset_ignored", 32'(fullState), 32'd1);
        applyStimulus(1, 1, 2'd1, 1, 3'b111, 3'b010, 0, 0);
        checkOutput("soft_reset_abort", 32'(detectAdd), 32'd1);

        // Reset in the middle of LOAD_DATA.
        applyStimulus(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        applyStimulus(0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        checkOutput("reset_mid_packet", 32'(detectAdd), 32'd1);

        // Randomized traffic with occasional resets and soft resets.
        for (int n = 0; n < 4000; n++) begin
            logic [NP-1:0] emp;
            logic [NP-1:0] sr;
            for (int p = 0; p < NP; p++) begin
                emp[p] = ($urandom_range(0, 9) < 4);
                sr[p]  = ($urandom_range(0, 39) == 0);
            end
            applyStimulus($urandom_range(0, 99) != 0,
                          $urandom_range(0, 9) < 8,
                          AW'($urandom_range(0, 3)),
                          $urandom_range(0, 4) == 0,
                          emp, sr,
                          $urandom_range(0, 9) < 3,
                          $urandom_range(0, 9) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_router_fsm_nport
